// File: rtl/usbfs_pkt_tx.sv
// usbfs_pkt_tx -- USB full-speed packet transmitter.
// Serialises one handshake or DATA packet per request onto {d+, d-} at
// 12 Mb/s (one bit time = 4 cycles of the 48 MHz clock). The packet is sent
// as SYNC, PID, optional payload, then CRC16. The bit stream is bit-stuffed
// and NRZI-encoded, then followed by EOP, after which the pad is released.
// Build option: define USBFS_PKT_TX_TOKEN_EN (host mode) to add i_addr/i_endp
// and send token-group PIDs with an 11-bit address/endpoint field plus CRC5.
`timescale 1ns/1ps
module usbfs_pkt_tx #(
    parameter int MAX_PKT = 8
) (
    input  logic                     i_clk_48MHz,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic [3:0]               i_pid,
    input  logic [8*MAX_PKT-1:0]     i_data,
    input  logic [$clog2(MAX_PKT):0] i_data_nBytes,
`ifdef USBFS_PKT_TX_TOKEN_EN
    input  logic [6:0]               i_addr,
    input  logic [3:0]               i_endp,
`endif
    output logic                     o_ready,
    output logic                     o_done,
    output logic                     o_oe,
    output logic                     o_dp,
    output logic                     o_dn
);
    localparam int BW  = $clog2(MAX_PKT);
    localparam int NBW = BW + 1;
    localparam logic [NBW-1:0] MAX_NB = NBW'(MAX_PKT);

    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_PID, S_DATA, S_CRC, S_TOK, S_LAST, S_EOP
    } state_t;

    state_t         state_reg;
    logic [1:0]     phase_reg;      // cycle within the current bit time
    logic [3:0]     bitCnt_reg;     // next raw bit to send within the field
    logic [BW-1:0]  byteCnt_reg;    // next payload byte to send
    logic [NBW-1:0] nBytes_reg;
    logic [3:0]     pid_reg;
    logic [7:0]     data_reg [MAX_PKT];
    logic [15:0]    crc16_reg;
    logic [2:0]     ones_reg;       // consecutive raw 1s already on the line
    logic           nrzi_reg;       // 1 = J, 0 = K
    logic [1:0]     eopCnt_reg;
`ifdef USBFS_PKT_TX_TOKEN_EN
    logic [10:0]    tokBits_reg;    // {endp, addr}, bit 0 sent first
    logic [4:0]     crc5_reg;
`endif

    logic [7:0]     dataIn [MAX_PKT];
    logic           accept;
    logic [NBW-1:0] nBytesSat;
    logic [7:0]     pidByte;
    logic           rawBit;
    logic           stuffDue;
    logic           lineNext;
    logic [15:0]    crc16Next;
    logic           lastByte;

    // Split the flat payload bus into bytes, byte 0 in the low bits.
    generate
        for (genvar gi = 0; gi < MAX_PKT; gi++) begin : g_unpack
            assign dataIn[gi] = i_data[8*gi +: 8];
        end
    endgenerate

    assign accept    = i_start && o_ready;
    assign nBytesSat = (i_data_nBytes > MAX_NB) ? MAX_NB : i_data_nBytes;
    assign pidByte   = {~pid_reg, pid_reg};
    assign stuffDue  = (ones_reg == 3'd6);
    assign lastByte  = (({1'b0, byteCnt_reg} + NBW'(1)) == nBytes_reg);
    // A stuffed bit is a raw 0, so it always toggles the line.
    assign lineNext  = (stuffDue || !rawBit) ? ~nrzi_reg : nrzi_reg;
    assign crc16Next = {crc16_reg[14:0], 1'b0} ^
                       ((rawBit ^ crc16_reg[15]) ? 16'h8005 : 16'h0000);

    // Select the raw bit that the field pointer currently addresses.
    always_comb begin
        rawBit = 1'b0;
        case (state_reg)
            S_SYNC: rawBit = (bitCnt_reg == 4'd7);
            S_PID:  rawBit = pidByte[bitCnt_reg[2:0]];
            S_DATA: rawBit = data_reg[byteCnt_reg][bitCnt_reg[2:0]];
            S_CRC:  rawBit = ~crc16_reg[15];
`ifdef USBFS_PKT_TX_TOKEN_EN
            S_TOK:  rawBit = (bitCnt_reg < 4'd11) ? tokBits_reg[bitCnt_reg] : ~crc5_reg[4];
`endif
            default: rawBit = 1'b0;
        endcase
    end

    // Payload capture at accept; held for the whole packet.
    always_ff @(posedge i_clk_48MHz) begin
        if (accept) begin
            data_reg <= dataIn;
        end
    end

    // Packet sequencer: field pointer, stuffing, NRZI, CRC and registered pad outputs.
    always_ff @(posedge i_clk_48MHz) begin
        if (i_rst) begin
            state_reg   <= S_IDLE;
            phase_reg   <= 2'd0;
            bitCnt_reg  <= 4'd0;
            byteCnt_reg <= '0;
            nBytes_reg  <= '0;
            pid_reg     <= 4'd0;
            crc16_reg   <= 16'hFFFF;
            ones_reg    <= 3'd0;
            nrzi_reg    <= 1'b1;
            eopCnt_reg  <= 2'd0;
`ifdef USBFS_PKT_TX_TOKEN_EN
            tokBits_reg <= 11'd0;
            crc5_reg    <= 5'h1F;
`endif
            o_ready     <= 1'b1;
            o_done      <= 1'b0;
            o_oe        <= 1'b0;
            o_dp        <= 1'b1;
            o_dn        <= 1'b0;
        end else begin
            phase_reg <= phase_reg + 2'd1;
            o_done    <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (i_start) begin
                        // First SYNC bit (raw 0) goes out immediately: J -> K.
                        state_reg   <= S_SYNC;
                        phase_reg   <= 2'd0;
                        bitCnt_reg  <= 4'd1;
                        byteCnt_reg <= '0;
                        nBytes_reg  <= nBytesSat;
                        pid_reg     <= i_pid;
                        crc16_reg   <= 16'hFFFF;
                        ones_reg    <= 3'd0;
                        nrzi_reg    <= 1'b0;
`ifdef USBFS_PKT_TX_TOKEN_EN
                        tokBits_reg <= {i_endp, i_addr};
                        crc5_reg    <= 5'h1F;
`endif
                        o_ready     <= 1'b0;
                        o_oe        <= 1'b1;
                        o_dp        <= 1'b0;
                        o_dn        <= 1'b1;
                    end
                end
                S_EOP: begin
                    if (phase_reg == 2'd3) begin
                        eopCnt_reg <= eopCnt_reg + 2'd1;
                        if (eopCnt_reg == 2'd1) begin
                            o_dp <= 1'b1;
                            o_dn <= 1'b0;
                        end
                    end else if (phase_reg == 2'd2 && eopCnt_reg == 2'd2) begin
                        // Final cycle of the J bit: release the pad and report.
                        state_reg <= S_IDLE;
                        o_oe      <= 1'b0;
                        o_done    <= 1'b1;
                        o_ready   <= 1'b1;
                    end
                end
                default: begin
                    if (phase_reg == 2'd3) begin
                        if (stuffDue) begin
                            // Stuffed 0: pointers and CRCs hold still.
                            ones_reg <= 3'd0;
                            nrzi_reg <= lineNext;
                            o_dp     <= lineNext;
                            o_dn     <= ~lineNext;
                        end else if (state_reg == S_LAST) begin
                            state_reg  <= S_EOP;
                            eopCnt_reg <= 2'd0;
                            o_dp       <= 1'b0;
                            o_dn       <= 1'b0;
                        end else begin
                            ones_reg <= rawBit ? ones_reg + 3'd1 : 3'd0;
                            nrzi_reg <= lineNext;
                            o_dp     <= lineNext;
                            o_dn     <= ~lineNext;
                            case (state_reg)
                                S_SYNC: begin
                                    if (bitCnt_reg == 4'd7) begin
                                        state_reg  <= S_PID;
                                        bitCnt_reg <= 4'd0;
                                    end else begin
                                        bitCnt_reg <= bitCnt_reg + 4'd1;
                                    end
                                end
                                S_PID: begin
                                    if (bitCnt_reg == 4'd7) begin
                                        bitCnt_reg <= 4'd0;
                                        if (pid_reg[1:0] == 2'b11) begin
                                            state_reg <= (nBytes_reg != '0) ? S_DATA : S_CRC;
`ifdef USBFS_PKT_TX_TOKEN_EN
                                        end else if (pid_reg[1:0] == 2'b01) begin
                                            state_reg <= S_TOK;
`endif
                                        end else begin
                                            state_reg <= S_LAST;
                                        end
                                    end else begin
                                        bitCnt_reg <= bitCnt_reg + 4'd1;
                                    end
                                end
                                S_DATA: begin
                                    crc16_reg <= crc16Next;
                                    if (bitCnt_reg == 4'd7) begin
                                        bitCnt_reg <= 4'd0;
                                        if (lastByte) begin
                                            state_reg <= S_CRC;
                                        end else begin
                                            byteCnt_reg <= byteCnt_reg + 1'b1;
                                        end
                                    end else begin
                                        bitCnt_reg <= bitCnt_reg + 4'd1;
                                    end
                                end
                                S_CRC: begin
                                    crc16_reg <= {crc16_reg[14:0], 1'b0};
                                    if (bitCnt_reg == 4'd15) begin
                                        state_reg  <= S_LAST;
                                        bitCnt_reg <= 4'd0;
                                    end else begin
                                        bitCnt_reg <= bitCnt_reg + 4'd1;
                                    end
                                end
`ifdef USBFS_PKT_TX_TOKEN_EN
                                S_TOK: begin
                                    if (bitCnt_reg < 4'd11) begin
                                        crc5_reg <= {crc5_reg[3:0], 1'b0} ^
                                                    ((rawBit ^ crc5_reg[4]) ? 5'h05 : 5'h00);
                                    end else begin
                                        crc5_reg <= {crc5_reg[3:0], 1'b0};
                                    end
                                    if (bitCnt_reg == 4'd15) begin
                                        state_reg  <= S_LAST;
                                        bitCnt_reg <= 4'd0;
                                    end else begin
                                        bitCnt_reg <= bitCnt_reg + 4'd1;
                                    end
                                end
`endif
                                default: ;
                            endcase
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_usbfs_pkt_tx.sv
// tb_usbfs_pkt_tx -- randomized self-checking bench for usbfs_pkt_tx.
// A packet-level model builds the expected line-state sequence per packet;
// one compare process checks every cycle, and a receiver decodes the capture.
`timescale 1ns/1ps
module tb_usbfs_pkt_tx;
    localparam int MAX_PKT = 8;
    localparam int NBW = $clog2(MAX_PKT) + 1;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic [3:0]           pid = 4'h0;
    logic [8*MAX_PKT-1:0] data = '0;
    logic [NBW-1:0]       nBytes = '0;
`ifdef USBFS_PKT_TX_TOKEN_EN
    logic [6:0]           addr = 7'd0;
    logic [3:0]           endp = 4'd0;
`endif
    logic ready, done, oe, dp, dn;

    usbfs_pkt_tx #(.MAX_PKT(MAX_PKT)) dut (
        .i_clk_48MHz   (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_pid         (pid),
        .i_data        (data),
        .i_data_nBytes (nBytes),
`ifdef USBFS_PKT_TX_TOKEN_EN
        .i_addr        (addr),
        .i_endp        (endp),
`endif
        .o_ready       (ready),
        .o_done        (done),
        .o_oe          (oe),
        .o_dp          (dp),
        .o_dn          (dn)
    );

    typedef struct packed {
        logic [1:0] line;
        logic       oe;
        logic       done;
        logic       ready;
    } exp_t;

    int   nTests = 0;
    int   nFails = 0;
    logic compareEn = 1'b0;
    exp_t expQ[$];
    logic [1:0] capQ[$];
    logic [1:0] mLine[$];
    int   mStuff;
    logic rxRaw[$];
    logic rxBits[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        nTests++;
        if (got !== want) begin
            nFails++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = b ^ c[15];
        crc_step = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    endfunction

    // Packet model: raw bit list -> stuffing -> NRZI line states -> EOP.
    task automatic build_model(input logic [3:0] p, input int n, input logic [63:0] d);
        logic raw[$];
        logic [15:0] crc;
        int ones;
        logic lvl;
        mLine.delete();
        mStuff = 0;
        for (int i = 0; i < 7; i++) raw.push_back(1'b0);
        raw.push_back(1'b1);
        for (int i = 0; i < 4; i++) raw.push_back(p[i]);
        for (int i = 0; i < 4; i++) raw.push_back(~p[i]);
        if (p[1:0] == 2'b11) begin
            crc = 16'hFFFF;
            for (int i = 0; i < 8*n; i++) begin
                raw.push_back(d[i]);
                crc = crc_step(crc, d[i]);
            end
            for (int i = 15; i >= 0; i--) raw.push_back(~crc[i]);
        end
        ones = 0;
        lvl = 1'b1;
        foreach (raw[i]) begin
            if (!raw[i]) lvl = ~lvl;
            mLine.push_back(lvl ? 2'b10 : 2'b01);
            ones = raw[i] ? ones + 1 : 0;
            if (ones == 6) begin
                lvl = ~lvl;
                mLine.push_back(lvl ? 2'b10 : 2'b01);
                mStuff++;
                ones = 0;
            end
        end
        mLine.push_back(2'b00);
        mLine.push_back(2'b00);
        mLine.push_back(2'b10);
    endtask

    task automatic push_records();
        int T;
        exp_t e;
        T = 4 * mLine.size();
        for (int c = 1; c <= T; c++) begin
            e.line  = mLine[(c-1)/4];
            e.oe    = (c < T);
            e.done  = (c == T);
            e.ready = (c == T);
            expQ.push_back(e);
        end
    endtask

    // Every cycle: DUT outputs against the model (idle values when no packet).
    always @(negedge clk) begin : cmp
        exp_t e;
        if (compareEn) begin
            if (expQ.size() > 0) e = expQ.pop_front();
            else begin
                e.line = 2'b10; e.oe = 1'b0; e.done = 1'b0; e.ready = 1'b1;
            end
            nTests++;
            if ({dp, dn} !== e.line || oe !== e.oe || done !== e.done || ready !== e.ready) begin
                nFails++;
                $display("FAIL cycle @%0t: got line=%b oe=%b done=%b ready=%b, want line=%b oe=%b done=%b ready=%b",
                         $time, {dp, dn}, oe, done, ready, e.line, e.oe, e.done, e.ready);
            end
            if (oe === 1'b1) capQ.push_back({dp, dn});
        end
    end

    // Receiver model: NRZI decode, destuff, then check SYNC, PID, payload, CRC16.
    task automatic rx_check(input logic [3:0] p, input int n, input logic [63:0] d);
        logic [1:0] prev, s;
        logic b, isData;
        int ones, stuffErr, wantLen;
        logic [7:0] byteV;
        logic [15:0] crc;
        rxRaw.delete();
        rxBits.delete();
        prev = 2'b10; ones = 0; stuffErr = 0;
        for (int i = 0; 4*i < capQ.size(); i++) begin
            s = capQ[4*i];
            if (s == 2'b00) break;
            b = (s == prev);
            prev = s;
            rxRaw.push_back(b);
            if (ones == 6) begin
                if (b) stuffErr++;
                ones = 0;
            end else begin
                rxBits.push_back(b);
                ones = b ? ones + 1 : 0;
            end
        end
        isData = (p[1:0] == 2'b11);
        wantLen = 16 + (isData ? 8*n + 16 : 0);
        check("rx_stuff_bit", stuffErr, 0);
        check("rx_len", rxBits.size(), wantLen);
        if (rxBits.size() == wantLen) begin
            for (int k = 0; k < 8; k++) byteV[k] = rxBits[k];
            check("rx_sync", byteV, 8'h80);
            for (int k = 0; k < 8; k++) byteV[k] = rxBits[8+k];
            check("rx_pid", byteV, {~p, p});
            if (isData) begin
                for (int j = 0; j < n; j++) begin
                    for (int k = 0; k < 8; k++) byteV[k] = rxBits[16 + 8*j + k];
                    check("rx_payload", byteV, d[8*j +: 8]);
                end
                crc = 16'hFFFF;
                for (int i = 16; i < wantLen; i++) crc = crc_step(crc, rxBits[i]);
                check("rx_crc_residual", crc, 16'h800D);
            end
        end
    endtask

    // Accept one request, then scramble the inputs so only captured values can matter.
    task automatic launch(input logic [3:0] p, input int nIn, input logic [63:0] d);
        @(negedge clk);
        pid = p; data = d; nBytes = NBW'(nIn); start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        pid = 4'($urandom);
        data = {$urandom, $urandom};
        nBytes = NBW'($urandom);
        capQ.delete();
        push_records();
    endtask

    task automatic run_packet(input logic [3:0] p, input int nIn, input logic [63:0] d);
        int n, T;
        n = (nIn > MAX_PKT) ? MAX_PKT : nIn;
        build_model(p, n, d);
        T = 4 * mLine.size();
        launch(p, nIn, d);
        repeat (T) @(posedge clk);
        #1;
        rx_check(p, n, d);
        $display("[TB] pkt pid=%h nBytes=%0d stuffed=%0d cycles=%0d", p, n, mStuff, T);
        repeat (2) @(posedge clk);
    endtask

    initial begin : main
        logic [15:0] s8;
        logic [17:0] pat;
        logic [7:0]  pb;
        logic [3:0]  p;
        logic [31:0] r;
        int T;

        repeat (3) @(posedge clk);
        #1;
        compareEn = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Model pins: ACK and zero-length DATA0 lengths, ACK SYNC line pattern.
        build_model(4'h2, 0, 64'd0);
        check("model_ack_cycles", 4 * mLine.size(), 76);
        check("model_ack_stuffed", mStuff, 0);
        s8 = '0;
        for (int i = 0; i < 8; i++) s8 = {s8[13:0], mLine[i]};
        check("model_sync_KJKJKJKK", s8, 16'b01_10_01_10_01_10_01_01);
        build_model(4'h3, 0, 64'd0);
        check("model_data0_empty_cycles", 4 * mLine.size(), 140);

        // ACK.
        run_packet(4'h2, 0, 64'd0);
        for (int k = 0; k < 8; k++) pb[k] = rxRaw[8+k];
        check("ack_pid_raw_bits", pb, 8'hD2);

        // DATA0 zero length: CRC bytes must be 00 00.
        run_packet(4'h3, 0, 64'd0);
        s8 = '1;
        if (rxBits.size() >= 32) for (int k = 0; k < 16; k++) s8[k] = rxBits[16+k];
        check("data0_empty_crc_bytes", s8, 16'h0000);

        // DATA1 FF FF: a 0 after every six payload 1s.
        run_packet(4'hB, 2, 64'h0000_0000_0000_FFFF);
        pat = '1;
        if (rxRaw.size() >= 34) for (int k = 0; k < 18; k++) pat[k] = rxRaw[16+k];
        check("data1_ffff_stuffing", pat, 18'b1111_0111111_0111111);

        // Length sweep with random data and random DATA-group PIDs.
        for (int n = 0; n <= MAX_PKT; n++) begin
            r = $urandom;
            p = {r[1:0], 2'b11};
            run_packet(p, n, {$urandom, $urandom});
        end
        run_packet(4'hB, 12, {$urandom, $urandom});       // saturates to MAX_PKT
        run_packet(4'h3, MAX_PKT, 64'hFFFF_FFFF_FFFF_FFFF);

        // Non-DATA groups are PID-only.
        for (int i = 0; i < 6; i++) begin
            r = $urandom;
            p = r[3:0];
            if (p[1:0] == 2'b11) p[1:0] = 2'b10;
`ifdef USBFS_PKT_TX_TOKEN_EN
            if (p[1:0] == 2'b01) p[1:0] = 2'b00;
`endif
            run_packet(p, int'(r[7:4]) % (MAX_PKT + 1), {$urandom, $urandom});
        end

        // Reset in the middle of payload byte 3: idle next cycle, no o_done.
        build_model(4'h3, MAX_PKT, {MAX_PKT{8'h55}});
        launch(4'h3, MAX_PKT, {MAX_PKT{8'h55}});
        repeat (4 * (16 + 24 + 4)) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        expQ.delete();
        rst = 1'b0;
        $display("[TB] reset mid-packet");
        repeat (3) @(posedge clk);
        run_packet(4'h2, 0, 64'd0);

        // i_start held high: back-to-back ACKs, each SYNC the cycle after o_done.
        build_model(4'h2, 0, 64'd0);
        T = 4 * mLine.size();
        @(negedge clk);
        pid = 4'h2; nBytes = '0; start = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            capQ.delete();
            push_records();
            if (k == 3) begin
                repeat (T - 1) @(posedge clk);
                @(negedge clk);
                start = 1'b0;
                @(posedge clk);
            end else begin
                repeat (T) @(posedge clk);
            end
            #1;
            rx_check(4'h2, 0, 64'd0);
            $display("[TB] b2b pkt %0d pid=2 cycles=%0d", k, T);
        end
        repeat (8) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", nTests, nFails);
        $finish;
    end
endmodule
